// File: rtl/dist_fifo_ctrl.sv
// dist_fifo_ctrl: valid/ready FIFO built around a distributed dual-port RAM
// (synchronous write, asynchronous read) followed by one registered output word.
// Capacity is DEPTH RAM entries plus the output register; fill latency is two cycles.
// Optional feature: define DIST_FIFO_LEVEL_EN to add the level_o occupancy port.
module dist_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH_RAM = 7
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
`ifdef DIST_FIFO_LEVEL_EN
    output logic [ADDR_WIDTH_RAM:0]   level_o,
`endif
    output logic [DATA_WIDTH-1:0]     out_data_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH_RAM;
    localparam logic [ADDR_WIDTH_RAM:0] DepthCnt = (ADDR_WIDTH_RAM + 1)'(Depth);

    logic [ADDR_WIDTH_RAM-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH_RAM-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH_RAM:0]   ram_cnt_q, ram_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;

    logic                      push;
    logic                      pop;
    logic                      load;
    logic [DATA_WIDTH-1:0]     ram_dout;

    // Distributed RAM storage (dist_ram_dp): write port at wr_ptr, async read at rd_ptr.
    // Contents are deliberately not reset.
    logic [DATA_WIDTH-1:0]     ram_mem [Depth];

    // RAM write port
    always_ff @(posedge clk_i) begin
        if (push) begin
            ram_mem[wr_ptr_q] <= in_data_i;
        end
    end

    assign ram_dout = ram_mem[rd_ptr_q];

    // Handshake decode; flush blocks both push and load so it wins over them
    always_comb begin
        in_ready_o = (ram_cnt_q != DepthCnt) && !flush_i;
        push       = in_valid_i && in_ready_o;
        pop        = out_valid_q && out_ready_i;
        load       = (ram_cnt_q != '0) && (!out_valid_q || out_ready_i) && !flush_i;
    end

    // Next-state for pointers, occupancy and the output register
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (flush_i) begin
            // A pop in this cycle is implicitly honoured by clearing out_valid; data is kept.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_cnt_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                out_data_d  = ram_dout;
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
            unique case ({push, load})
                2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
                2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
                default: ram_cnt_d = ram_cnt_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

`ifdef DIST_FIFO_LEVEL_EN
    // Total words held: RAM entries plus the output register
    always_comb begin
        level_o = ram_cnt_q + {{ADDR_WIDTH_RAM{1'b0}}, out_valid_q};
    end
`endif

endmodule

// File: tb/tb_dist_fifo_ctrl.sv
// Directed testbench for dist_fifo_ctrl with DATA_WIDTH=32, ADDR_WIDTH_RAM=2 (DEPTH=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_dist_fifo_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef DIST_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dist_fifo_ctrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH_RAM (AW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
`ifdef DIST_FIFO_LEVEL_EN
        .level_o     (level),
`endif
        .out_data_o  (out_data)
    );

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_0000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data got=%h exp=00000000", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
`ifdef DIST_FIFO_LEVEL_EN
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("FAIL reset_level got=%0d exp=0", level);
        end
`endif
        // Nothing offered during reset may surface afterwards
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_push got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // After the push edge: word is in RAM, output register still empty
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge_n got=%b exp=0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL latency_edge_n1 got=%b/%h exp=1/a5a50001", out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL latency_popped got=%b/%h exp=0/a5a50001", out_valid, out_data);
        end
    endtask

    task automatic test_full();
        int n_out;
        bit pushed6;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = i;
            #1;
            checks++;
            if (in_ready !== (i <= 5)) begin
                errors++;
                $display("FAIL full_in_ready word=%0d got=%b exp=%b", i, in_ready, (i <= 5));
            end
        end
        // 0x6 stays offered while the FIFO is full; head word must hold
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1) begin
            errors++;
            $display("FAIL full_hold got=%b/%b/%h exp=0/1/00000001", in_ready, out_valid, out_data);
        end
`ifdef DIST_FIFO_LEVEL_EN
        checks++;
        if (level !== 3'd5) begin
            errors++;
            $display("FAIL full_level got=%0d exp=5", level);
        end
`endif
        out_ready = 1'b1;
        #1;
        // A pop this cycle does not open space in the same cycle
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_same_cycle got=%b exp=0", in_ready);
        end
        n_out   = 0;
        pushed6 = 1'b0;
        for (int c = 0; c < 30 && n_out < 6; c++) begin
            if (out_valid) begin
                checks++;
                if (out_data !== 32'(n_out + 1)) begin
                    errors++;
                    $display("FAIL full_drain idx=%0d got=%h exp=%h", n_out, out_data, n_out + 1);
                end
                n_out++;
            end
            if (in_valid && in_ready) pushed6 = 1'b1;
            @(posedge clk);
            #1;
            if (pushed6) in_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (n_out != 6 || !pushed6) begin
            errors++;
            $display("FAIL full_drain_count got=%0d pushed6=%b exp=6/1", n_out, pushed6);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_after got=%b/%b exp=1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_throughput();
        int next_in;
        int next_out;
        int c;
        next_in   = 0;
        next_out  = 0;
        out_ready = 1'b1;
        c         = 0;
        while (next_out < 100 && c < 400) begin
            @(negedge clk);
            in_valid = (next_in < 100);
            in_data  = next_in;
            #1;
            if (out_valid) begin
                checks++;
                if (out_data !== 32'(next_out)) begin
                    errors++;
                    $display("FAIL thru_data idx=%0d got=%h exp=%h", next_out, out_data, next_out);
                end
                next_out++;
            end else if (c >= 2 && next_out < 100) begin
                checks++;
                errors++;
                $display("FAIL thru_gap cycle=%0d got=0 exp=1", c);
            end
            if (in_valid && in_ready) next_in++;
            else if (in_valid) begin
                checks++;
                errors++;
                $display("FAIL thru_in_ready cycle=%0d got=0 exp=1", c);
            end
            c++;
        end
        in_valid = 1'b0;
        // Output k appears at sample k+2, so 100 words take 102 samples
        checks++;
        if (next_out != 100 || c != 102) begin
            errors++;
            $display("FAIL thru_count got=%0d/%0d exp=100/102", next_out, c);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_w;
        logic [DW-1:0] prev_data;
        logic          prev_stall;
        int sent;
        int recv;
        int c;
        sent       = 0;
        recv       = 0;
        c          = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (recv < 1000 && c < 20000) begin
            @(negedge clk);
            in_valid  = (sent < 1000) && ($urandom_range(99) < 70);
            in_data   = $urandom;
            out_ready = ($urandom_range(1) == 1);
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL bp_stable got=%b/%h exp=1/%h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_spurious got=%h exp=none", out_data);
                end else begin
                    exp_w = q.pop_front();
                    if (out_data !== exp_w) begin
                        errors++;
                        $display("FAIL bp_data idx=%0d got=%h exp=%h", recv, out_data, exp_w);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got=%0d left=%0d exp=1000/0", recv, q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_flush();
        int c;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'hF000_0000 + i;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
`ifdef DIST_FIFO_LEVEL_EN
        checks++;
        if (level !== 3'd3) begin
            errors++;
            $display("FAIL flush_level_before got=%0d exp=3", level);
        end
`endif
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hF000_0000) begin
            errors++;
            $display("FAIL flush_head got=%b/%h exp=1/f0000000", out_valid, out_data);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_1234;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_push got=%b exp=0", in_ready);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'hF000_0000) begin
            errors++;
            $display("FAIL flush_after got=%b/%b/%h exp=0/1/f0000000", out_valid, in_ready,
                     out_data);
        end
`ifdef DIST_FIFO_LEVEL_EN
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("FAIL flush_level got=%0d exp=0", level);
        end
`endif
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'h0000_BEEF;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL flush_first_word got=%b/%h exp=1/0000beef", out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drained got=%b exp=0", out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_latency();
        test_full();
        test_throughput();
        test_back_to_back();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
